// File: rtl/jtag_dm_sba.sv
// RISC-V debug module System Bus Access engine: decodes the sbcs/sbaddress/sbdata
// DMI registers and masters the ICB bus with sized, autoincrementing accesses.
module jtag_dm_sba #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dmi_req_valid,
  output logic                dmi_req_ready,
  input  logic [5:0]          dmi_req_addr,
  input  logic [1:0]          dmi_req_op,
  input  logic [31:0]         dmi_req_data,
  output logic                dmi_rsp_valid,
  input  logic                dmi_rsp_ready,
  output logic [31:0]         dmi_rsp_data,
  output logic [1:0]          dmi_rsp_op,
  output logic                icb_cmd_valid,
  input  logic                icb_cmd_ready,
  output logic [ADDR_W-1:0]   icb_cmd_addr,
  output logic                icb_cmd_read,
  output logic [DATA_W-1:0]   icb_cmd_wdata,
  output logic [DATA_W/8-1:0] icb_cmd_wmask,
  input  logic                icb_rsp_valid,
  output logic                icb_rsp_ready,
  input  logic                icb_rsp_err,
  input  logic [DATA_W-1:0]   icb_rsp_rdata
);
  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned LB = $clog2(NB);
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [4:0] SIZES = (DATA_W == 64) ? 5'b01111 : 5'b00111;

  typedef enum logic [1:0] {IDLE, CMD, RSP} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busyerr_q, busyerr_d, roa_q, roa_d, autoinc_q, autoinc_d, rod_q, rod_d;
  logic [2:0]        access_q, access_d, sberr_q, sberr_d, acc_q, acc_d;
  logic              rd_q, rd_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;

  logic              accept, busy, sb_reg, drop, trig, trig_rd, misalign, tmo_hit, in_cmd;
  logic [63:0]       addr64, data64;
  logic [31:0]       sbcs;
  logic [LB-1:0]     off;
  logic [DATA_W-1:0] rd_shift, rd_mask, wdata;
  logic [NB-1:0]     mask_base;

  assign busy     = (state_q != IDLE);
  assign in_cmd   = (state_q == CMD);
  assign accept   = dmi_req_valid && !rsp_valid_q;
  assign off      = addr_q[LB-1:0];
  assign sb_reg   = dmi_req_addr inside {6'h39, 6'h3A, 6'h3C, 6'h3D};
  assign drop     = busy && sb_reg && (dmi_req_op == 2'd1 || dmi_req_op == 2'd2);
  assign sbcs     = {3'd1, 6'd0, busyerr_q, busy, roa_q, access_q, autoinc_q, rod_q,
                     sberr_q, 7'(ADDR_W), SIZES};
  assign tmo_hit  = (TIMEOUT_CYC != 0) && (tmo_q + TW'(1) == TW'(TIMEOUT_CYC));
  assign rd_shift = icb_rsp_rdata >> {off, 3'b000};

  always_comb begin
    rd_mask   = '1;
    mask_base = '1;
    wdata     = data_q;
    case (acc_q)
      3'd0: begin
        rd_mask = DATA_W'(8'hFF); mask_base = NB'(1); wdata = {NB{data_q[7:0]}};
      end
      3'd1: begin
        rd_mask = DATA_W'(16'hFFFF); mask_base = NB'(3); wdata = {(NB/2){data_q[15:0]}};
      end
      3'd2: begin
        rd_mask = DATA_W'(32'hFFFF_FFFF); mask_base = NB'(15);
        wdata = {(DATA_W/32){data_q[31:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    busyerr_d   = busyerr_q;
    roa_d       = roa_q;
    access_d    = access_q;
    autoinc_d   = autoinc_q;
    rod_d       = rod_q;
    sberr_d     = sberr_q;
    acc_d       = acc_q;
    rd_d        = rd_q;
    tmo_d       = tmo_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    addr64      = 64'(addr_q);
    data64      = 64'(data_q);
    trig        = 1'b0;
    trig_rd     = 1'b0;
    misalign    = 1'b0;

    if (rsp_valid_q && dmi_rsp_ready) rsp_valid_d = 1'b0;

    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = '0;
      if (drop) busyerr_d = 1'b1;
      if (dmi_req_op == 2'd1) begin
        case (dmi_req_addr)
          6'h38: rsp_data_d = sbcs;
          6'h39: rsp_data_d = addr64[31:0];
          6'h3A: rsp_data_d = addr64[63:32];
          6'h3C: rsp_data_d = data64[31:0];
          6'h3D: rsp_data_d = data64[63:32];
          default: ;
        endcase
        // The read returns the old sbdata0; the bus read refills it afterwards.
        if (dmi_req_addr == 6'h3C && !busy && rod_q) begin
          trig = 1'b1; trig_rd = 1'b1;
        end
      end else if (dmi_req_op == 2'd2 && !drop) begin
        case (dmi_req_addr)
          6'h38: begin
            busyerr_d = busyerr_q & ~dmi_req_data[22];
            roa_d     = dmi_req_data[20];
            access_d  = dmi_req_data[19:17];
            autoinc_d = dmi_req_data[16];
            rod_d     = dmi_req_data[15];
            sberr_d   = sberr_q & ~dmi_req_data[14:12];
          end
          6'h39: begin
            addr64[31:0] = dmi_req_data;
            if (roa_q) begin trig = 1'b1; trig_rd = 1'b1; end
          end
          6'h3A: addr64[63:32] = dmi_req_data;
          6'h3C: begin data64[31:0] = dmi_req_data; trig = 1'b1; end
          6'h3D: data64[63:32] = dmi_req_data;
          default: ;
        endcase
      end
    end

    addr_d = addr64[ADDR_W-1:0];
    data_d = data64[DATA_W-1:0];

    case (access_q)
      3'd1: misalign = addr_d[0];
      3'd2: misalign = |addr_d[1:0];
      3'd3: misalign = |addr_d[2:0];
      default: ;
    endcase

    if (trig && sberr_q == 3'd0 && !busyerr_q) begin
      if (access_q > 3'd3 || (access_q == 3'd3 && DATA_W != 64)) sberr_d = 3'd4;
      else if (misalign) sberr_d = 3'd3;
      else begin
        state_d = CMD;
        acc_d   = access_q;
        rd_d    = trig_rd;
        tmo_d   = '0;
      end
    end

    // Bus events are applied last so a bus error beats a same-cycle W1C of sberror.
    case (state_q)
      CMD: begin
        tmo_d = tmo_q + TW'(1);
        if (tmo_hit) begin
          state_d = IDLE; sberr_d = 3'd1;
        end else if (icb_cmd_ready) state_d = RSP;
      end
      RSP: begin
        tmo_d = tmo_q + TW'(1);
        if (icb_rsp_valid) begin
          state_d = IDLE;
          if (icb_rsp_err) sberr_d = 3'd2;
          else begin
            if (rd_q) data_d = rd_shift & rd_mask;
            if (autoinc_q) addr_d = addr_q + (ADDR_W'(1) << acc_q);
          end
        end else if (tmo_hit) begin
          state_d = IDLE; sberr_d = 3'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      busyerr_q   <= 1'b0;
      roa_q       <= 1'b0;
      access_q    <= 3'd2;
      autoinc_q   <= 1'b0;
      rod_q       <= 1'b0;
      sberr_q     <= '0;
      acc_q       <= 3'd2;
      rd_q        <= 1'b0;
      tmo_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      busyerr_q   <= busyerr_d;
      roa_q       <= roa_d;
      access_q    <= access_d;
      autoinc_q   <= autoinc_d;
      rod_q       <= rod_d;
      sberr_q     <= sberr_d;
      acc_q       <= acc_d;
      rd_q        <= rd_d;
      tmo_q       <= tmo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign dmi_req_ready = !rsp_valid_q;
  assign dmi_rsp_valid = rsp_valid_q;
  assign dmi_rsp_data  = rsp_data_q;
  assign dmi_rsp_op    = 2'b00;
  assign icb_cmd_valid = in_cmd;
  assign icb_cmd_addr  = in_cmd ? addr_q : '0;
  assign icb_cmd_read  = in_cmd && rd_q;
  assign icb_cmd_wdata = in_cmd ? wdata : '0;
  assign icb_cmd_wmask = in_cmd ? (mask_base << off) : '0;
  assign icb_rsp_ready = 1'b1;

endmodule

// File: tb/tb_jtag_dm_sba.sv
// Directed bench for jtag_dm_sba: DMI register sequences against a scripted ICB
// slave, with hand-computed expected sbcs/address/data/bus-command values.
module tb_jtag_dm_sba;
  logic        clk = 1'b0;
  logic        rst;
  logic        dmi_req_valid = 1'b0;
  logic        dmi_req_ready;
  logic [5:0]  dmi_req_addr = '0;
  logic [1:0]  dmi_req_op = '0;
  logic [31:0] dmi_req_data = '0;
  logic        dmi_rsp_valid;
  logic        dmi_rsp_ready = 1'b0;
  logic [31:0] dmi_rsp_data;
  logic [1:0]  dmi_rsp_op;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready = 1'b1;
  logic [31:0] icb_cmd_addr;
  logic        icb_cmd_read;
  logic [31:0] icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid = 1'b0;
  logic        icb_rsp_ready;
  logic        icb_rsp_err = 1'b0;
  logic [31:0] icb_rsp_rdata = '0;

  int          checks = 0;
  int          errors = 0;
  int          cmd_count = 0;
  int          cv_cycles = 0;
  logic [31:0] last_addr = '0, last_wdata = '0;
  logic [3:0]  last_wmask = '0;
  logic        last_read = 1'b0;
  logic        hold_rsp = 1'b0, err_cfg = 1'b0, pending = 1'b0;
  logic [31:0] rdata_cfg = '0;
  logic [31:0] r;

  jtag_dm_sba #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(15)) dut (
    .clk(clk), .rst(rst),
    .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
    .dmi_req_addr(dmi_req_addr), .dmi_req_op(dmi_req_op), .dmi_req_data(dmi_req_data),
    .dmi_rsp_valid(dmi_rsp_valid), .dmi_rsp_ready(dmi_rsp_ready),
    .dmi_rsp_data(dmi_rsp_data), .dmi_rsp_op(dmi_rsp_op),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
    .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
    .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
    .icb_rsp_err(icb_rsp_err), .icb_rsp_rdata(icb_rsp_rdata)
  );

  always #5 clk = ~clk;

  // Scripted ICB slave: logs each accepted command, answers one cycle later unless held.
  initial begin
    forever begin
      @(negedge clk);
      if (pending && !hold_rsp) begin
        icb_rsp_valid = 1'b1; icb_rsp_rdata = rdata_cfg; icb_rsp_err = err_cfg; pending = 1'b0;
      end else begin
        icb_rsp_valid = 1'b0; icb_rsp_err = 1'b0;
      end
      if (icb_cmd_valid) cv_cycles++;
      if (icb_cmd_valid && icb_cmd_ready) begin
        cmd_count++;
        last_addr = icb_cmd_addr; last_wdata = icb_cmd_wdata;
        last_wmask = icb_cmd_wmask; last_read = icb_cmd_read;
        pending = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic dmi(input logic [5:0] a, input logic [1:0] op, input logic [31:0] d,
                     output logic [31:0] rd);
    int n;
    rd = '0;
    @(negedge clk);
    dmi_req_valid = 1'b1; dmi_req_addr = a; dmi_req_op = op; dmi_req_data = d;
    n = 0;
    while (!dmi_req_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    dmi_req_valid = 1'b0;
    n = 0;
    while (!dmi_rsp_valid && n < 20) begin @(negedge clk); n++; end
    if (!dmi_rsp_valid) begin
      checks++; errors++;
      $display("FAIL dmi_rsp_timeout: addr %0h no response within 20 cycles", a);
    end
    rd = dmi_rsp_data;
    dmi_rsp_ready = 1'b1;
    @(negedge clk);
    dmi_rsp_ready = 1'b0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    dmi(a, 2'd2, d, dummy);
  endtask

  task automatic rdchk(input string tag, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] v;
    dmi(a, 2'd1, 32'h0, v);
    chk(tag, 64'(v), 64'(exp));
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rsp_ready", 64'(icb_rsp_ready), 64'd1);
    chk("rst_cmd_valid", 64'(icb_cmd_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_dmi_rsp_valid", 64'(dmi_rsp_valid), 64'd0);
    chk("rst_req_ready", 64'(dmi_req_ready), 64'd1);
    chk("rst_wmask", 64'(icb_cmd_wmask), 64'd0);
    rdchk("rst_sbcs", 6'h38, 32'h2004_0407);
    rdchk("rst_sbaddr0", 6'h39, 32'h0);
    rdchk("rst_sbdata0", 6'h3C, 32'h0);
    rdchk("unmapped_read", 6'h10, 32'h0);
    rdchk("sbaddr1_absent", 6'h3A, 32'h0);

    // 1: 32-bit write
    wr(6'h38, 32'h0004_0000);
    wr(6'h39, 32'h0000_0100);
    hold_rsp = 1'b1;
    wr(6'h3C, 32'hDEAD_BEEF);
    rdchk("t1_sbcs_busy", 6'h38, 32'h2024_0407);
    hold_rsp = 1'b0;
    settle();
    chk("t1_cmd_count", 64'(cmd_count), 64'd1);
    chk("t1_addr", 64'(last_addr), 64'h100);
    chk("t1_wmask", 64'(last_wmask), 64'hF);
    chk("t1_wdata", 64'(last_wdata), 64'hDEAD_BEEF);
    chk("t1_read", 64'(last_read), 64'd0);
    rdchk("t1_sbcs_idle", 6'h38, 32'h2004_0407);

    // 2: byte read on address write, lane 3
    wr(6'h38, 32'h0010_0000);
    rdata_cfg = 32'h1122_3344;
    wr(6'h39, 32'h0000_0203);
    settle();
    chk("t2_cmd_count", 64'(cmd_count), 64'd2);
    chk("t2_read", 64'(last_read), 64'd1);
    chk("t2_addr", 64'(last_addr), 64'h203);
    rdchk("t2_sbdata0", 6'h3C, 32'h0000_0011);

    // 3: read-on-data with autoincrement
    wr(6'h38, 32'h0005_8000);
    wr(6'h39, 32'h0000_1000);
    chk("t3_no_trigger", 64'(cmd_count), 64'd2);
    for (int i = 0; i < 3; i++) begin
      rdata_cfg = 32'hA0A0_0000 + 32'(i);
      rdchk("t3_sbdata0_prev", 6'h3C, (i == 0) ? 32'h11 : 32'hA0A0_0000 + 32'(i - 1));
      settle();
      chk("t3_addr", 64'(last_addr), 64'h1000 + 64'(4 * i));
    end
    chk("t3_cmd_count", 64'(cmd_count), 64'd5);
    rdchk("t3_sbaddr0_end", 6'h39, 32'h0000_100C);

    // 4: misaligned halfword, clear, aligned retry, byte write lanes
    wr(6'h38, 32'h0012_0000);
    wr(6'h39, 32'h0000_0201);
    settle();
    chk("t4_no_cmd", 64'(cmd_count), 64'd5);
    rdchk("t4_sbcs_err3", 6'h38, 32'h2012_3407);
    wr(6'h38, 32'h0012_7000);
    rdchk("t4_sbcs_clear", 6'h38, 32'h2012_0407);
    rdata_cfg = 32'h5566_7788;
    wr(6'h39, 32'h0000_0202);
    settle();
    chk("t4_retry_count", 64'(cmd_count), 64'd6);
    chk("t4_retry_addr", 64'(last_addr), 64'h202);
    rdchk("t4_sbdata0", 6'h3C, 32'h0000_5566);
    wr(6'h38, 32'h0000_0000);
    wr(6'h39, 32'h0000_0301);
    wr(6'h3C, 32'h0000_00AB);
    settle();
    chk("t4_byte_count", 64'(cmd_count), 64'd7);
    chk("t4_byte_wdata", 64'(last_wdata), 64'hABAB_ABAB);
    chk("t4_byte_wmask", 64'(last_wmask), 64'h2);

    // 5: timeout with cmd_ready held low
    wr(6'h38, 32'h0004_0000);
    wr(6'h39, 32'h0000_0400);
    icb_cmd_ready = 1'b0;
    cv_cycles = 0;
    wr(6'h3C, 32'h0000_1234);
    repeat (25) @(negedge clk);
    chk("t5_cmd_cycles", 64'(cv_cycles), 64'd15);
    rdchk("t5_sbcs_err1", 6'h38, 32'h2004_1407);
    icb_cmd_ready = 1'b1;
    wr(6'h3C, 32'h0000_5555);
    settle();
    chk("t5_blocked", 64'(cmd_count), 64'd7);
    wr(6'h38, 32'h0004_7000);
    wr(6'h3C, 32'h0000_5555);
    settle();
    chk("t5_after_clear", 64'(cmd_count), 64'd8);
    chk("t5_wdata", 64'(last_wdata), 64'h5555);
    chk("t5_addr", 64'(last_addr), 64'h400);

    // 6: busy error while stalled in RSP, then bus error
    wr(6'h39, 32'h0000_0500);
    hold_rsp = 1'b1;
    err_cfg  = 1'b1;
    wr(6'h3C, 32'h0000_0001);
    wr(6'h3C, 32'h0000_0002);
    chk("t6_single_cmd", 64'(cmd_count), 64'd9);
    hold_rsp = 1'b0;
    settle();
    err_cfg = 1'b0;
    chk("t6_cmd_count", 64'(cmd_count), 64'd9);
    rdchk("t6_sbcs", 6'h38, 32'h2044_2407);
    rdchk("t6_sbdata0", 6'h3C, 32'h0000_0001);
    rdchk("t6_sbaddr0", 6'h39, 32'h0000_0500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
    $fatal(1, "watchdog");
  end

endmodule
